// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle through a shared
// complement-and-add subtract path, driven by a start/busy/done handshake.
module alu_seq_divider #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // The partial remainder always ends an iteration below the divisor, so only
    // the shifted value and the difference need the extra guard bit.
    logic             subs;
    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   b_op;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        subs   = (state_q == CALC);
        rs     = {r_q, q_q[WIDTH-1]};
        b_op   = {1'b0, d_q} ^ {(WIDTH+1){subs}};
        diff   = rs + b_op + {{WIDTH{1'b0}}, subs};
        r_next = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next = {q_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d   = divisor;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = dividend;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    quot_d  = q_next;
                    rem_d   = r_next;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed-vector bench for alu_seq_divider: latency, busy window, results, and
// the ignored-start and mid-operation reset corner cases.
module tb_alu_seq_divider;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_q"},    32'(quotient), 0);
        chk({tag, "_r"},    32'(remainder), 0);
        chk({tag, "_dbz"},  32'(div_by_zero), 0);
    endtask

    // Issues one division; inj_cyc injects a second start mid-operation,
    // rst_cyc aborts with reset (0 disables either).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic z, input int inj_cyc, input int rst_cyc);
        int cyc;
        int busy_cnt;
        int done_cnt;
        bit seen;
        @(negedge clk);
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        cyc      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && cyc <= 2 * W) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (cyc == inj_cyc) begin
                    start    = 1'b1;
                    dividend = 24'd50;
                    divisor  = 24'd5;
                end else begin
                    start = 1'b0;
                end
                if (cyc == rst_cyc) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk_zero_outputs("rst_abort");
                    done_cnt = 0;
                    for (int i = 0; i < 2 * W; i++) begin
                        @(negedge clk);
                        if (done) done_cnt++;
                    end
                    chk("rst_no_done", done_cnt, 0);
                    chk("rst_stays_idle", 32'(busy), 0);
                    return;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("latency",   cyc, z ? 1 : W + 1);
        chk("busy_cyc",  busy_cnt, z ? 0 : W);
        chk("busy_at_done", 32'(busy), 0);
        chk("quotient",  32'(quotient), 32'(q));
        chk("remainder", 32'(remainder), 32'(r));
        chk("dbz",       32'(div_by_zero), 32'(z));
    endtask

    initial begin
        vecs[0] = '{24'd100,     24'd7,        24'd14,       24'd2,        1'b0};
        vecs[1] = '{24'hFFFFFF,  24'd1,        24'hFFFFFF,   24'd0,        1'b0};
        vecs[2] = '{24'hFFFFFF,  24'hFFFFFF,   24'd1,        24'd0,        1'b0};
        vecs[3] = '{24'd5,       24'd0,        24'hFFFFFF,   24'd5,        1'b1};
        vecs[4] = '{24'd9,       24'd3,        24'd3,        24'd0,        1'b0};
        vecs[5] = '{24'd3,       24'd10,       24'd0,        24'd3,        1'b0};
        vecs[6] = '{24'd0,       24'd9,        24'd0,        24'd0,        1'b0};
        vecs[7] = '{24'h800000,  24'd3,        24'd2796202,  24'd2,        1'b0};
        vecs[8] = '{24'hFFFFFE,  24'hFFFFFF,   24'd0,        24'hFFFFFE,   1'b0};
        vecs[9] = '{24'd1000,    24'd3,        24'd333,      24'd1,        1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 0, 0);

        // start during CALC must neither queue nor recapture operands
        run_op(24'd1000, 24'd3, 24'd333, 24'd1, 1'b0, 5, 0);

        // reset mid-operation aborts it; a fresh division then completes normally
        run_op(24'd1000, 24'd3, 24'd333, 24'd1, 1'b0, 0, 10);
        run_op(24'd20, 24'd6, 24'd3, 24'd2, 1'b0, 0, 0);

        // divide-by-zero flag must clear on the next accepted start
        run_op(24'd7, 24'd0, 24'hFFFFFF, 24'd7, 1'b1, 0, 0);
        run_op(24'd100, 24'd7, 24'd14, 24'd2, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
